univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_if.sv | 26 ++
 rtl/univ_shift_reg.sv | 111 +++++++++++
 tb/tb_univ_shift_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: operation/serial/parallel inputs and registered outputs.
// The master side drives operations; the slave side is the register itself.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2:0]       i_op;
  logic             i_sin_l;
  logic             i_sin_r;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_q;
  logic             o_sout;
  logic [CNT_W-1:0] o_cnt;
  logic             o_done;

  modport master (
    output i_op, i_sin_l, i_sin_r, i_data,
    input  o_q, o_sout, o_cnt, o_done
  );

  modport slave (
    input  i_op, i_sin_l, i_sin_r, i_data,
    output o_q, o_sout, o_cnt, o_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/shift/arith-shift with serial-out, shift counter and done pulse.
// Define USR_ROTATE_EN to enable rotate ops 100/101; otherwise they act as hold.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  univ_shift_reg_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] q_d,    q_q;
  logic             sout_d, sout_q;
  logic [CNT_W-1:0] cnt_d,  cnt_q;
  logic             done_d, done_q;
  logic             is_shift;

  assign op = op_e'(bus.i_op);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave one unassigned (no latches).
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;

    case (op)
      OP_HOLD: ;
      OP_LOAD: begin
        q_d   = bus.i_data;
        cnt_d = '0;
      end
      OP_CLEAR: begin
        q_d    = '0;
        cnt_d  = '0;
        sout_d = 1'b0;
      end
      OP_SHL: begin
        q_d      = {q_q[WIDTH-2:0], bus.i_sin_r};
        sout_d   = q_q[WIDTH-1];
        is_shift = 1'b1;
      end
      OP_SHR: begin
        q_d      = {bus.i_sin_l, q_q[WIDTH-1:1]};
        sout_d   = q_q[0];
        is_shift = 1'b1;
      end
`ifdef USR_ROTATE_EN
      OP_ROL: begin
        q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_d   = q_q[WIDTH-1];
        is_shift = 1'b1;
      end
      OP_ROR: begin
        q_d      = {q_q[0], q_q[WIDTH-1:1]};
        sout_d   = q_q[0];
        is_shift = 1'b1;
      end
`else
      OP_ROL, OP_ROR: ;
`endif
      OP_ASR: begin
        q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        sout_d   = q_q[0];
        is_shift = 1'b1;
      end
      default: ;
    endcase

    // Saturating count; the pulse fires only on the W-1 -> W step, so shifts at saturation stay silent.
    if (is_shift && (cnt_q < CNT_MAX)) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == CNT_MAX - 1'b1);
    end
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (i_rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.o_q    = q_q;
  assign bus.o_sout = sout_q;
  assign bus.o_cnt  = cnt_q;
  assign bus.o_done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8; rotate expectations follow USR_ROTATE_EN.
module tb_univ_shift_reg;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] q, input logic sout,
                             input logic [3:0] cnt, input logic done);
    check({tag, ".q"},    32'(bus.o_q),    32'(q));
    check({tag, ".sout"}, 32'(bus.o_sout), 32'(sout));
    check({tag, ".cnt"},  32'(bus.o_cnt),  32'(cnt));
    check({tag, ".done"}, 32'(bus.o_done), 32'(done));
  endtask

  // Drive inputs well away from the edge, clock once, then settle before checking.
  task automatic apply(input logic [2:0] op, input logic [7:0] data,
                       input logic sin_l, input logic sin_r);
    bus.i_op    = op;
    bus.i_data  = data;
    bus.i_sin_l = sin_l;
    bus.i_sin_r = sin_r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] shr_q    [8];
  logic       shr_sout [8];
  logic [7:0] asr_q    [3];

  initial begin
    tests  = 0;
    failed = 0;
    shr_q    = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    shr_sout = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    asr_q    = '{8'hC0, 8'hE0, 8'hF0};

    rst = 1'b1;
    bus.i_op = 3'b000; bus.i_data = 8'h00; bus.i_sin_l = 1'b0; bus.i_sin_r = 1'b0;

    // Reset beats a load request for three cycles.
    for (int i = 0; i < 3; i++) begin
      apply(3'b001, 8'hA5, 1'b1, 1'b1);
      check_state($sformatf("rst%0d", i), 8'h00, 1'b0, 4'd0, 1'b0);
    end
    rst = 1'b0;

    apply(3'b001, 8'hA5, 1'b0, 1'b0);
    check_state("load_a5", 8'hA5, 1'b0, 4'd0, 1'b0);
    apply(3'b010, 8'h00, 1'b0, 1'b1);
    check_state("shl", 8'h4B, 1'b1, 4'd1, 1'b0);

    // Shift right to saturation: pulse on the 8th shift only.
    apply(3'b001, 8'h81, 1'b0, 1'b0);
    check_state("load_81", 8'h81, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(3'b011, 8'h00, 1'b0, 1'b1);
      check_state($sformatf("shr%0d", i + 1), shr_q[i], shr_sout[i], 4'(i + 1), (i == 7));
    end
    apply(3'b011, 8'h00, 1'b0, 1'b0);
    check_state("shr9", 8'h00, 1'b0, 4'd8, 1'b0);
    apply(3'b000, 8'h00, 1'b0, 1'b0);
    check_state("hold_sat", 8'h00, 1'b0, 4'd8, 1'b0);

    // A load on the cycle that would saturate wins, no pulse.
    apply(3'b001, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) apply(3'b010, 8'h00, 1'b0, 1'b0);
    check_state("shl7", 8'h80, 1'b1, 4'd7, 1'b0);
    apply(3'b001, 8'h3C, 1'b0, 1'b0);
    check_state("load_wins", 8'h3C, 1'b1, 4'd0, 1'b0);
    apply(3'b000, 8'h00, 1'b0, 1'b0);
    check_state("load_wins_hold", 8'h3C, 1'b1, 4'd0, 1'b0);

    // Arithmetic shift right ignores serial inputs.
    apply(3'b001, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(3'b110, 8'h00, 1'b0, 1'b1);
      check_state($sformatf("asr%0d", i + 1), asr_q[i], 1'b0, 4'(i + 1), 1'b0);
    end

    apply(3'b001, 8'h81, 1'b0, 1'b0);
    apply(3'b100, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    check_state("rol", 8'h03, 1'b1, 4'd1, 1'b0);
    apply(3'b101, 8'h00, 1'b0, 1'b0);
    check_state("ror", 8'h81, 1'b1, 4'd2, 1'b0);
`else
    check_state("rol_hold", 8'h81, 1'b0, 4'd0, 1'b0);
    apply(3'b101, 8'h00, 1'b0, 1'b0);
    check_state("ror_hold", 8'h81, 1'b0, 4'd0, 1'b0);
`endif

    // Clear mid-count, then count restarts from zero.
    apply(3'b001, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply(3'b010, 8'h00, 1'b0, 1'b0);
    check_state("shl5", 8'h20, 1'b0, 4'd5, 1'b0);
    apply(3'b111, 8'h00, 1'b0, 1'b0);
    check_state("clear", 8'h00, 1'b0, 4'd0, 1'b0);
    apply(3'b011, 8'h00, 1'b1, 1'b0);
    check_state("post_clr1", 8'h80, 1'b0, 4'd1, 1'b0);
    apply(3'b011, 8'h00, 1'b1, 1'b0);
    check_state("post_clr2", 8'hC0, 1'b0, 4'd2, 1'b0);
    apply(3'b011, 8'h00, 1'b1, 1'b0);
    check_state("post_clr3", 8'hE0, 1'b0, 4'd3, 1'b0);
    apply(3'b000, 8'h00, 1'b0, 1'b0);
    check_state("post_clr_hold", 8'hE0, 1'b0, 4'd3, 1'b0);

    // Reset mid-sequence overrides a shift.
    apply(3'b011, 8'h00, 1'b1, 1'b0);
    check_state("pre_rst", 8'hF0, 1'b0, 4'd4, 1'b0);
    rst = 1'b1;
    apply(3'b011, 8'h00, 1'b1, 1'b0);
    check_state("mid_rst", 8'h00, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    apply(3'b010, 8'h00, 1'b0, 1'b1);
    check_state("after_rst", 8'h01, 1'b0, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
